pcm_frame_unpacker: RTL
=======================

Name: pcm_frame_unpacker

Overview:
- Pulls one PCM frame of CHANNELS × SAMPLE_BITS from the byte FIFO (fifo_extmem read handshake) on every sample-rate enable.
- Assembles the bytes into per-channel words and presents all channels atomically to the sigma-delta DACs.
- Generalises the fixed 2ch/16-bit/4-byte unpacking to any channel count, sample width and byte order.
- Counts underruns (frame due but not enough bytes buffered) and overruns (enable arrives while a frame is still being fetched).

Parameters:
- CHANNELS, 2: number of interleaved channels per frame; ≥1.
- SAMPLE_BITS, 16: bits per channel sample; multiple of 8, 8..32.
- BIG_ENDIAN, 1: 1 = first byte of a sample is its MSB; 0 = first byte is its LSB.
- FILL_BITS, 20: width of the fifo_fill input.
- CNT_BITS, 16: width of the underrun/overrun counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- sample_en  in  1  one-cycle frame strobe from counter_clock_enable.
- fifo_fill  in  FILL_BITS  bytes currently in FIFO.
- fifo_rd_en  out  1  level read request to FIFO.
- fifo_rd_data  in  8  byte from FIFO; valid when fifo_completed=1.
- fifo_completed  in  1  one-cycle pulse per byte delivered.
- samples_out  out  CHANNELS*SAMPLE_BITS  channel 0 in the LSB slice.
- samples_valid  out  1  one-cycle pulse when samples_out updates.
- busy  out  1  high in FETCH state.
- underrun_count  out  CNT_BITS  saturating count of underruns.
- overrun_count  out  CNT_BITS  saturating count of overruns.

Behaviour:
- FRAME_BYTES = CHANNELS*SAMPLE_BITS/8. Byte index counter is $clog2(FRAME_BYTES+1) bits wide.
- Reset (reset_n=0 at a clk edge):
  - state=IDLE.
  - fifo_rd_en, samples_valid, busy = 0.
  - samples_out = 0; counters = 0; staging register cleared.
  - Reset in FETCH abandons the partial frame; bytes already consumed are not returned.
- IDLE:
  - sample_en=1 and fifo_fill ≥ FRAME_BYTES → FETCH; fifo_rd_en=1 from the next cycle; byte index=0.
  - sample_en=1 and fifo_fill < FRAME_BYTES → underrun_count+1 (saturating); stay in IDLE; samples_out holds the last frame.
- FETCH:
  - fifo_rd_en held high.
  - Each fifo_completed stores fifo_rd_data into the staging register at byte index, then index+1.
  - Byte k belongs to channel k / (SAMPLE_BITS/8). Position within the sample is MSB-first if BIG_ENDIAN, else LSB-first.
  - Channel 0 is the first channel in the stream.
  - On the completed pulse for byte FRAME_BYTES-1: fifo_rd_en=0 on the next cycle; state→IDLE.
  - In that same next cycle, samples_out is loaded with the full staged frame (including the final byte) and samples_valid pulses for one cycle.
  - Latency: last completed at cycle N → outputs/valid at N+1.
- Overrun: sample_en=1 while in FETCH → overrun_count+1 (saturating); the strobe is dropped; the current fetch continues.
- Same-cycle sample_en and final completed: counts as an overrun; no new fetch is started.
- fifo_completed while in IDLE is ignored; no state change.
- samples_out never changes except at the samples_valid cycle or at reset. No partial-frame updates are visible.
- Counters stick at all-ones.

Optional Feature:
- Macro PCM_OFFSET_BINARY_EN.
- Defined:
  - Each assembled sample has its MSB inverted before loading samples_out (two's complement → offset binary, as required by the unsigned sigma-delta DAC).
  - Reset value of each channel slice is 1<<(SAMPLE_BITS-1) (midscale).
- Undefined: samples are passed raw; reset value is 0.

Test Plan:
- Default params; FIFO model with fill=4 returning bytes 0x12,0x34,0x56,0x78, one completed every 3 cycles; pulse sample_en → samples_out = {0x5678,0x1234}; samples_valid exactly 1 cycle, one cycle after the 4th completed; fifo_rd_en low the following cycle.
- BIG_ENDIAN=0, CHANNELS=3, SAMPLE_BITS=24; bytes 0x01..0x09 → ch0=0x030201, ch1=0x060504, ch2=0x090807.
- fill=3, pulse sample_en → no fifo_rd_en; underrun_count 0→1; samples_out unchanged; 5 more strobes → count=6.
- sample_en pulsed again mid-FETCH, and again on the final-completed cycle → overrun_count=2; exactly one samples_valid; next IDLE strobe starts a new fetch.
- reset_n=0 after 2 of 4 bytes → rd_en=0, outputs 0 (midscale 0x8000 per channel with PCM_OFFSET_BINARY_EN); a subsequent full frame loads correctly with no stale bytes.
- PCM_OFFSET_BINARY_EN defined; bytes 0x80,0x00,0x7F,0xFF → samples_out = {0xFFFF,0x0000}.

Source files
------------

// File: rtl/pcm_frame_unpacker.sv
// Fetches one interleaved PCM frame from the byte FIFO on each sample strobe and presents all channels at once.
// Optional macro PCM_OFFSET_BINARY_EN: inverts each sample MSB (offset binary) and resets channels to midscale.
module pcm_frame_unpacker #(
  parameter int CHANNELS    = 2,
  parameter int SAMPLE_BITS = 16,
  parameter int BIG_ENDIAN  = 1,
  parameter int FILL_BITS   = 20,
  parameter int CNT_BITS    = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            sample_en,
  input  logic [FILL_BITS-1:0]            fifo_fill,
  output logic                            fifo_rd_en,
  input  logic [7:0]                      fifo_rd_data,
  input  logic                            fifo_completed,
  output logic [CHANNELS*SAMPLE_BITS-1:0] samples_out,
  output logic                            samples_valid,
  output logic                            busy,
  output logic [CNT_BITS-1:0]             underrun_count,
  output logic [CNT_BITS-1:0]             overrun_count
);

  localparam int BPS         = SAMPLE_BITS / 8;
  localparam int FRAME_BYTES = CHANNELS * BPS;
  localparam int IDX_W       = $clog2(FRAME_BYTES + 1);
  localparam int OUT_W       = CHANNELS * SAMPLE_BITS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       stage_p0 [FRAME_BYTES];
  logic [OUT_W-1:0] frame_p0;
  logic [OUT_W-1:0] frame_conv_p0;
  logic             start, last_byte, underrun_evt, overrun_evt;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

`ifdef PCM_OFFSET_BINARY_EN
  function automatic logic [OUT_W-1:0] to_offset(input logic [OUT_W-1:0] f);
    logic [OUT_W-1:0] r;
    r = f;
    for (int c = 0; c < CHANNELS; c++)
      r[c*SAMPLE_BITS + SAMPLE_BITS - 1] = ~f[c*SAMPLE_BITS + SAMPLE_BITS - 1];
    return r;
  endfunction

  localparam logic [OUT_W-1:0] RESET_FRAME = to_offset('0);
  assign frame_conv_p0 = to_offset(frame_p0);
`else
  localparam logic [OUT_W-1:0] RESET_FRAME = '0;
  assign frame_conv_p0 = frame_p0;
`endif

  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    last_byte    = 1'b0;
    underrun_evt = 1'b0;
    overrun_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_en) begin
          if (fifo_fill >= FILL_BITS'(FRAME_BYTES)) begin
            state_nxt = FETCH;
            start     = 1'b1;
          end else begin
            underrun_evt = 1'b1;
          end
        end
      end
      FETCH: begin
        overrun_evt = sample_en;
        if (fifo_completed && idx == IDX_W'(FRAME_BYTES - 1)) begin
          last_byte = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rd_en = (state == FETCH);
  assign busy       = (state == FETCH);

  // Stage 0 -> frame: the final byte bypasses staging so the whole frame loads on the cycle after it arrives
  for (genvar k = 0; k < FRAME_BYTES; k++) begin : g_byte
    localparam int CH   = k / BPS;
    localparam int POS  = k % BPS;
    localparam int SLOT = (BIG_ENDIAN != 0) ? (BPS - 1 - POS) : POS;
    assign frame_p0[CH*SAMPLE_BITS + SLOT*8 +: 8] =
      (fifo_completed && idx == IDX_W'(k)) ? fifo_rd_data : stage_p0[k];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      samples_out    <= RESET_FRAME;
      samples_valid  <= 1'b0;
      underrun_count <= '0;
      overrun_count  <= '0;
      for (int k = 0; k < FRAME_BYTES; k++) stage_p0[k] <= '0;
    end else begin
      state         <= state_nxt;
      samples_valid <= last_byte;
      if (start) begin
        idx <= '0;
      end else if (state == FETCH && fifo_completed) begin
        for (int k = 0; k < FRAME_BYTES; k++)
          if (idx == IDX_W'(k)) stage_p0[k] <= fifo_rd_data;
        idx <= idx + 1'b1;
      end
      if (last_byte)    samples_out    <= frame_conv_p0;
      if (underrun_evt) underrun_count <= sat_inc(underrun_count);
      if (overrun_evt)  overrun_count  <= sat_inc(overrun_count);
    end
  end

endmodule
